// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV64I opcodes and issue skid state shared by issue and ALU
package alu_pkg;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_ADDW = 5'd10;
    localparam logic [4:0] ALU_SUBW = 5'd11;
    localparam logic [4:0] ALU_SLLW = 5'd12;
    localparam logic [4:0] ALU_SRLW = 5'd13;
    localparam logic [4:0] ALU_SRAW = 5'd14;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef enum logic {SKID_PASS, SKID_HOLD} skid_state_t;

    // funct3 of OP/OP-IMM to the non-alternate ALU op (funct7 bit 5 clear)
    function automatic logic [4:0] f3_ctl(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV64I instruction -> ALU control/operand decode
// Ports: instr, pc, rs1_data, rs2_data in; alu_control, src_1, src_2, illegal out.
// ALU_ISSUE_RV64W_EN enables OP-32 / OP-IMM-32 word-op decode.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CONTROL_WIDTH = 5
) (
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    output logic [CONTROL_WIDTH-1:0] alu_control,
    output logic [DATA_WIDTH-1:0]    src_1,
    output logic [DATA_WIDTH-1:0]    src_2,
    output logic                     illegal
);
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [5:0] imm_hi;
    logic [DATA_WIDTH-1:0] imm_i, imm_u, shamt, s1, s2;
    logic [4:0] ctl;
    logic ok;
    logic unused_rd;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_hi    = instr[31:26];
    assign imm_i     = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_u     = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
    assign shamt     = {{(DATA_WIDTH-6){1'b0}}, instr[25:20]};
    assign unused_rd = ^instr[11:7];

`ifdef ALU_ISSUE_RV64W_EN
    logic [DATA_WIDTH-1:0] shamt_w;
    logic [4:0] ctl_w;
    assign shamt_w = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
    assign ctl_w   = funct3 == 3'b001 ? ALU_SLLW :
                     funct3 == 3'b101 ? (funct7[5] ? ALU_SRAW : ALU_SRLW) :
                                        (funct7[5] ? ALU_SUBW : ALU_ADDW);
`endif

    always_comb begin
        ctl = ALU_ADD;
        ok  = 1'b0;
        s1  = rs1_data;
        s2  = rs2_data;
        case (opcode)
            OPC_OP: begin
                ctl = funct7[5] ? (funct3[2] ? ALU_SRA : ALU_SUB) : f3_ctl(funct3);
                ok  = funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                ctl = funct3 == 3'b101 ? (imm_hi[4] ? ALU_SRA : ALU_SRL) : f3_ctl(funct3);
                s2  = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
                ok  = funct3 == 3'b001 ? imm_hi == 6'b000000 :
                      funct3 == 3'b101 ? (imm_hi == 6'b000000 || imm_hi == 6'b010000) : 1'b1;
            end
            OPC_LUI: begin
                s1 = '0;
                s2 = imm_u;
                ok = 1'b1;
            end
            OPC_AUIPC: begin
                s1 = pc;
                s2 = imm_u;
                ok = 1'b1;
            end
`ifdef ALU_ISSUE_RV64W_EN
            OPC_OP_32: begin
                ctl = ctl_w;
                ok  = (funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM_32: begin
                // ADDIW immediate overlaps funct7, so it must not select SUBW
                ctl = funct3 == 3'b000 ? ALU_ADDW : ctl_w;
                s2  = funct3 == 3'b000 ? imm_i : shamt_w;
                ok  = funct3 == 3'b000 ||
                      (funct3 == 3'b001 && funct7 == 7'b0000000) ||
                      (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000));
            end
`endif
            default: ok = 1'b0;
        endcase
    end

    assign illegal     = !ok;
    assign alu_control = CONTROL_WIDTH'(ok ? ctl : ALU_ADD);
    assign src_1       = ok ? s1 : '0;
    assign src_2       = ok ? s2 : '0;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes RV64I ALU instructions and issues them through a one-entry skid buffer
// Ports: i_clk, i_arst; upstream i_valid/o_ready, i_instr, i_pc, i_rs1_data, i_rs2_data;
// downstream o_valid/i_ready, o_alu_control, o_src_1, o_src_2, o_illegal.
// ALU_ISSUE_RV64W_EN enables word-op decode in alu_issue_decode.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CONTROL_WIDTH = 5
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_instr,
    input  logic [DATA_WIDTH-1:0]    i_pc,
    input  logic [DATA_WIDTH-1:0]    i_rs1_data,
    input  logic [DATA_WIDTH-1:0]    i_rs2_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [CONTROL_WIDTH-1:0] o_alu_control,
    output logic [DATA_WIDTH-1:0]    o_src_1,
    output logic [DATA_WIDTH-1:0]    o_src_2,
    output logic                     o_illegal
);
    logic [CONTROL_WIDTH-1:0] dec_control, skid_control;
    logic [DATA_WIDTH-1:0] dec_src_1, dec_src_2, skid_src_1, skid_src_2;
    logic dec_illegal, skid_illegal;
    skid_state_t state;

    alu_issue_decode #(
        .DATA_WIDTH(DATA_WIDTH),
        .CONTROL_WIDTH(CONTROL_WIDTH)
    ) u_decode (
        .instr(i_instr),
        .pc(i_pc),
        .rs1_data(i_rs1_data),
        .rs2_data(i_rs2_data),
        .alu_control(dec_control),
        .src_1(dec_src_1),
        .src_2(dec_src_2),
        .illegal(dec_illegal)
    );

    // o_ready mirrors state == SKID_PASS but is kept as its own register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state         <= SKID_PASS;
            o_ready       <= 1'b1;
            o_valid       <= 1'b0;
            o_alu_control <= '0;
            o_src_1       <= '0;
            o_src_2       <= '0;
            o_illegal     <= 1'b0;
            skid_control  <= '0;
            skid_src_1    <= '0;
            skid_src_2    <= '0;
            skid_illegal  <= 1'b0;
        end else if (state == SKID_HOLD) begin
            if (i_ready) begin
                o_alu_control <= skid_control;
                o_src_1       <= skid_src_1;
                o_src_2       <= skid_src_2;
                o_illegal     <= skid_illegal;
                state         <= SKID_PASS;
                o_ready       <= 1'b1;
            end
        end else if (i_valid && o_ready) begin
            if (!o_valid || i_ready) begin
                o_valid       <= 1'b1;
                o_alu_control <= dec_control;
                o_src_1       <= dec_src_1;
                o_src_2       <= dec_src_2;
                o_illegal     <= dec_illegal;
            end else begin
                skid_control <= dec_control;
                skid_src_1   <= dec_src_1;
                skid_src_2   <= dec_src_2;
                skid_illegal <= dec_illegal;
                state        <= SKID_HOLD;
                o_ready      <= 1'b0;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue
module tb_alu_issue;
    localparam int DW = 64;
    localparam int CW = 5;

    logic i_clk = 1'b0;
    logic i_arst, i_valid, i_ready, o_ready, o_valid, o_illegal;
    logic [31:0] i_instr;
    logic [DW-1:0] i_pc, i_rs1_data, i_rs2_data, o_src_1, o_src_2;
    logic [CW-1:0] o_alu_control;
    int checks = 0;
    int errors = 0;

    alu_issue #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) dut (
        .i_clk(i_clk),
        .i_arst(i_arst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_instr(i_instr),
        .i_pc(i_pc),
        .i_rs1_data(i_rs1_data),
        .i_rs2_data(i_rs2_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_alu_control(o_alu_control),
        .o_src_1(o_src_1),
        .o_src_2(o_src_2),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
        return {imm, 5'd2, f3, 5'd1, op};
    endfunction

    task automatic set_in(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b);
        i_instr = ins;
        i_pc = pc;
        i_rs1_data = a;
        i_rs2_data = b;
        i_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b);
        set_in(ins, pc, a, b);
        step();
        i_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] ctl, input logic [63:0] s1,
                              input logic [63:0] s2, input logic ill);
        check({tag, ".valid"}, 64'(o_valid), 64'd1);
        check({tag, ".ctl"}, 64'(o_alu_control), 64'(ctl));
        check({tag, ".src1"}, o_src_1, s1);
        check({tag, ".src2"}, o_src_2, s2);
        check({tag, ".illegal"}, 64'(o_illegal), 64'(ill));
    endtask

    initial begin
        i_arst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_instr = '0;
        i_pc = '0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        #12;
        check("rst.valid", 64'(o_valid), 64'd0);
        check("rst.ready", 64'(o_ready), 64'd1);
        check("rst.ctl", 64'(o_alu_control), 64'd0);
        check("rst.src1", o_src_1, 64'd0);
        @(negedge i_clk);
        i_arst = 1'b0;
        step();

        issue(rtype(7'b0000000, 3'b000, 7'b0110011), 64'h0, 64'd5, 64'd7);
        expect_out("add", 5'd0, 64'd5, 64'd7, 1'b0);
        step();
        check("bubble.valid", 64'(o_valid), 64'd0);

        issue(rtype(7'b0100000, 3'b000, 7'b0110011), 64'h0, 64'd20, 64'd3);
        expect_out("sub", 5'd1, 64'd20, 64'd3, 1'b0);
        issue(rtype(7'b0000000, 3'b011, 7'b0110011), 64'h0, 64'd1, 64'd2);
        expect_out("sltu", 5'd7, 64'd1, 64'd2, 1'b0);
        issue(rtype(7'b0100000, 3'b001, 7'b0110011), 64'h0, 64'd1, 64'd2);
        expect_out("op_bad_f7", 5'd0, 64'd0, 64'd0, 1'b1);
        issue(itype(12'hFFB, 3'b000, 7'b0010011), 64'h0, 64'd9, 64'd0);
        expect_out("addi_neg", 5'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        issue(itype(12'h43F, 3'b101, 7'b0010011), 64'h0, 64'h8000_0000_0000_0000, 64'd0);
        expect_out("srai63", 5'd9, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
        issue(itype(12'h83F, 3'b101, 7'b0010011), 64'h0, 64'd4, 64'd4);
        expect_out("srai_bad", 5'd0, 64'd0, 64'd0, 1'b1);
        issue(itype(12'h005, 3'b001, 7'b0010011), 64'h0, 64'd4, 64'd0);
        expect_out("slli", 5'd5, 64'd4, 64'd5, 1'b0);
        issue({20'h12345, 5'd1, 7'b0010111}, 64'h1000, 64'd0, 64'd0);
        expect_out("auipc", 5'd0, 64'h1000, 64'h1234_5000, 1'b0);
        issue({20'h80000, 5'd1, 7'b0110111}, 64'h1000, 64'd3, 64'd3);
        expect_out("lui_neg", 5'd0, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        issue(rtype(7'b0000000, 3'b000, 7'b1100011), 64'h40, 64'd6, 64'd6);
        expect_out("branch_op", 5'd0, 64'd0, 64'd0, 1'b1);
`ifdef ALU_ISSUE_RV64W_EN
        issue(itype(12'hFFF, 3'b000, 7'b0011011), 64'h0, 64'd8, 64'd0);
        expect_out("addiw", 5'd10, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        issue(rtype(7'b0100000, 3'b101, 7'b0111011), 64'h0, 64'd8, 64'd2);
        expect_out("sraw", 5'd14, 64'd8, 64'd2, 1'b0);
        issue(itype(12'h020, 3'b001, 7'b0011011), 64'h0, 64'd8, 64'd0);
        expect_out("slliw_bad", 5'd0, 64'd0, 64'd0, 1'b1);
`else
        issue(itype(12'hFFF, 3'b000, 7'b0011011), 64'h0, 64'd8, 64'd0);
        expect_out("addiw_off", 5'd0, 64'd0, 64'd0, 1'b1);
        issue(rtype(7'b0000000, 3'b000, 7'b0111011), 64'h0, 64'd8, 64'd2);
        expect_out("addw_off", 5'd0, 64'd0, 64'd0, 1'b1);
`endif
        step();

        // back-to-back A, B, C with a two-cycle stall
        i_ready = 1'b0;
        set_in(rtype(7'b0000000, 3'b000, 7'b0110011), 64'h0, 64'd1, 64'd11);
        step();
        expect_out("seq.a", 5'd0, 64'd1, 64'd11, 1'b0);
        check("seq.ready_a", 64'(o_ready), 64'd1);
        set_in(rtype(7'b0000000, 3'b100, 7'b0110011), 64'h0, 64'd3, 64'd13);
        step();
        check("seq.ready_b", 64'(o_ready), 64'd0);
        expect_out("seq.stall1", 5'd0, 64'd1, 64'd11, 1'b0);
        set_in(rtype(7'b0000000, 3'b110, 7'b0110011), 64'h0, 64'd5, 64'd15);
        step();
        check("seq.ready_hold", 64'(o_ready), 64'd0);
        expect_out("seq.stall2", 5'd0, 64'd1, 64'd11, 1'b0);
        i_ready = 1'b1;
        step();
        expect_out("seq.b", 5'd4, 64'd3, 64'd13, 1'b0);
        check("seq.ready_pass", 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        expect_out("seq.c", 5'd3, 64'd5, 64'd15, 1'b0);
        step();
        check("seq.drain", 64'(o_valid), 64'd0);

        // reset while holding a stalled entry plus a skid entry
        i_ready = 1'b0;
        issue(rtype(7'b0100000, 3'b000, 7'b0110011), 64'h0, 64'd9, 64'd4);
        issue(rtype(7'b0000000, 3'b111, 7'b0110011), 64'h0, 64'd2, 64'd2);
        check("hold.ready", 64'(o_ready), 64'd0);
        #2;
        i_arst = 1'b1;
        #1;
        check("arst.valid", 64'(o_valid), 64'd0);
        check("arst.ready", 64'(o_ready), 64'd1);
        check("arst.ctl", 64'(o_alu_control), 64'd0);
        check("arst.src1", o_src_1, 64'd0);
        check("arst.src2", o_src_2, 64'd0);
        @(negedge i_clk);
        i_arst = 1'b0;
        i_ready = 1'b1;
        issue(rtype(7'b0000000, 3'b000, 7'b0110011), 64'h0, 64'd5, 64'd7);
        expect_out("post_rst", 5'd0, 64'd5, 64'd7, 1'b0);
        step();
        check("post_rst.drain", 64'(o_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 64: operand and result width.
REQ-002 Parameter CONTROL_WIDTH, default 5: ALU control code width.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_arst  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  upstream has an instruction.
REQ-006 o_ready  output  1  block can accept an instruction.
REQ-007 i_instr  input  32  RV64I instruction word.
REQ-008 i_pc  input  DATA_WIDTH  instruction address.
REQ-009 i_rs1_data / i_rs2_data  input  DATA_WIDTH  register operands.
REQ-010 o_valid  output  1  issued operation is valid.
REQ-011 i_ready  input  1  ALU stage accepts the operation.
REQ-012 o_alu_control  output  CONTROL_WIDTH  ALU op code.
REQ-013 o_src_1 / o_src_2  output  DATA_WIDTH  ALU operands.
REQ-014 o_illegal  output  1  instruction not decodable to an ALU op.

Function
REQ-015 Control codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SLT 6, SLTU 7, SRL 8, SRA 9, ADDW 10, SUBW 11, SLLW 12, SRLW 13, SRAW 14.
REQ-016 OP (0110011): funct7 0000000 -> funct3 op; funct7 0100000 with funct3 000 -> SUB, 101 -> SRA; any other funct7/funct3 pair illegal; src_1=rs1, src_2=rs2.
REQ-017 OP-IMM (0010011): src_2 = sign-extended imm[11:0]; shifts use src_2 = zero-extended shamt[5:0], imm[11:6] 000000 (SLLI/SRLI) or 010000 (SRAI only), else illegal.
REQ-018 LUI: ADD, src_1=0, src_2 = sign-extended {imm[31:12],12'b0}; AUIPC: same with src_1=i_pc.
REQ-019 Any other opcode: o_illegal=1, o_alu_control=ADD, both sources 0.
REQ-020 Transfer in when i_valid&o_ready; out when o_valid&i_ready; latency exactly 1 cycle from accept to o_valid.
REQ-021 Storage: output register plus one skid register; states PASS (skid empty) and HOLD (skid full).
REQ-022 PASS: accept while output empty or drained this cycle -> output register; accept while output full and stalled -> skid, go HOLD.
REQ-023 HOLD: o_ready=0; on output transfer skid moves to output, return PASS.
REQ-024 o_ready is a register output, never combinational from i_ready.
REQ-025 Output payload stable while o_valid=1 and i_ready=0.
REQ-026 Simultaneous in/out transfer in PASS with output full: new entry replaces output, no bubble, order preserved.

Reset
REQ-027 Asserting i_arst at any time, including mid-stall, immediately sets o_valid=0, o_ready=1, state PASS, skid empty, o_alu_control=0, o_src_1=0, o_src_2=0, o_illegal=0; in-flight entries discarded.

Configuration
REQ-028 ALU_ISSUE_RV64W_EN defined: OP-32 (0111011) decodes ADDW/SUBW/SLLW/SRLW/SRAW, OP-IMM-32 (0011011) decodes ADDIW->ADDW, SLLIW, SRLIW, SRAIW; shamt imm[25]=1 illegal.
REQ-029 ALU_ISSUE_RV64W_EN undefined: both opcodes illegal per REQ-019; no word-op decode logic synthesised.

Structure
REQ-030 Package alu_pkg holds control code constants, opcode constants, skid state enum; shared with the ALU.
REQ-031 Sub-module alu_issue_decode: purely combinational instruction/operand decode; alu_issue holds handshake and storage only.

Verification
REQ-032 ADD x, rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, control 0, srcs 5/7, o_illegal=0.
REQ-033 SRAI shamt 63 (imm[11:6]=010000) -> control 9, src_2=63; imm[11:6]=100000 -> o_illegal=1, srcs 0.
REQ-034 Three back-to-back instructions, i_ready=0 two cycles -> o_ready falls after second accept, third held upstream, all three delivered in order, payload stable during stall.
REQ-035 AUIPC imm 0x12345, pc 0x1000 -> control 0, src_1=0x1000, src_2=0x12345000.
REQ-036 ADDIW imm -1: macro on -> control 10, src_2=all ones; macro off -> o_illegal=1.
REQ-037 i_arst asserted during HOLD -> same cycle o_valid=0, o_ready=1; first post-reset instruction issues normally.
